// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and sizing constants for the round-robin arbiter
package arb_pkg;
  localparam int NREQ = 4;
  localparam int IDW = 2;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;
endpackage

// File: rtl/gnt_decoder.sv
// gnt_decoder: 2x4 decoder with enable that turns the holder index into one-hot select lines
module gnt_decoder
  import arb_pkg::*;
(
  input  logic [IDW-1:0]  gnt_id,
  input  logic            gnt_valid,
  output logic [NREQ-1:0] gnt
);
  // one-hot select for the holder, all-zero when no grant is active
  always_comb gnt = gnt_valid ? NREQ'(1) << gnt_id : '0;
endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with release on done, withdraw or hold timeout
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_valid
);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d;
  logic           valid_q, valid_d;
  logic [7:0]     hold_q, hold_d;
  logic           release_c;
  function automatic logic [IDW-1:0] pick(input logic [NREQ-1:0] r, input logic [IDW-1:0] p);
    logic [IDW-1:0] idx, c;
    idx = p;
    for (int k = NREQ - 1; k >= 0; k--) begin
      c = p + IDW'(k);
      if (r[c]) idx = c;
    end
    return idx;
  endfunction
  // next-state: grant the first requester from ptr in IDLE, release on done/withdraw/timeout in GRANT
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    valid_d   = valid_q;
    hold_d    = hold_q;
    release_c = done || !req[id_q] || (HOLD_MAX != 0 && hold_q == HOLD_LAST);
    if (state_q == IDLE) begin
      if (|req) begin
        id_d    = pick(req, ptr_q);
        valid_d = 1'b1;
        hold_d  = '0;
        state_d = GRANT;
      end
    end else if (release_c) begin
      ptr_d   = id_q + IDW'(1);
      valid_d = 1'b0;
      state_d = IDLE;
    end else begin
      hold_d = hold_q == 8'hff ? hold_q : hold_q + 8'd1;
    end
  end
  // state registers, synchronous reset has priority over every input
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
    end
  end
  assign gnt_id    = id_q;
  assign gnt_valid = valid_q;
  gnt_decoder u_dec (
    .gnt_id   (id_q),
    .gnt_valid(valid_q),
    .gnt      (gnt)
  );
endmodule
